// File: rtl/fir_pkg.sv
// Shared constants for the 5-tap symmetric low-pass FIR.
//   DATA_W    : input sample width (unsigned)
//   OUT_W     : output width (unsigned)
//   TAPS      : number of taps (fixed)
//   SUM_W     : width of the full-precision coefficient sum (max 2040)
//   COEF      : tap weights applied to d0..d4, all powers of two
//   OUT_SHIFT : right shift applied to the sum before registering
package fir_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned OUT_W     = 10;
    localparam int unsigned TAPS      = 5;
    localparam int unsigned SUM_W     = 11;
    localparam int unsigned OUT_SHIFT = 1;

    localparam int unsigned COEF [TAPS] = '{1, 2, 2, 2, 1};

    // Coefficients are powers of two, so each multiply reduces to a left shift.
    function automatic int unsigned coef_shift(input int unsigned coef);
        int unsigned s;
        s = 0;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) == coef) begin
                s = i;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/fir_filter_tap_reg.sv
// One delay-line stage of the FIR tap chain.
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low clear
//   d_i    : sample from the previous stage (or the filter input)
//   q_o    : registered sample
module fir_tap_reg
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fir_filter.sv
// 5-tap fixed-coefficient low-pass FIR, one sample in and one result out per clock.
//   clk     : clock, rising edge
//   rst     : synchronous active-low reset; clears the delay line and output
//   x       : unsigned input sample, captured every edge out of reset
//   dataout : registered filtered output, floor((d0 + 2d1 + 2d2 + 2d3 + d4) / 2)
module fir_filter
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x,
    output logic [OUT_W-1:0]  dataout
);

    // taps[0] is the newest sample, taps[TAPS-1] the oldest.
    logic [DATA_W-1:0] taps [TAPS];
    logic [SUM_W-1:0]  terms [TAPS];

    logic [SUM_W-1:0] sum_01;
    logic [SUM_W-1:0] sum_23;
    logic [SUM_W-1:0] sum_0123;
    logic [SUM_W-1:0] sum_all;

    logic [OUT_W-1:0] dataout_d;
    logic [OUT_W-1:0] dataout_q;

    for (genvar i = 0; i < TAPS; i++) begin : g_taps
        logic [DATA_W-1:0] stage_in;

        if (i == 0) begin : g_head
            assign stage_in = x;
        end else begin : g_link
            assign stage_in = taps[i-1];
        end

        fir_tap_reg #(
            .WIDTH (DATA_W)
        ) u_tap (
            .clk_i  (clk),
            .rst_ni (rst),
            .d_i    (stage_in),
            .q_o    (taps[i])
        );

        // Zero-extend before shifting so the weighted tap cannot lose its top bits.
        assign terms[i] = SUM_W'(taps[i]) << coef_shift(COEF[i]);
    end

    // Balanced pairing; SUM_W covers the worst case of 2040 so no carry is lost.
    always_comb begin
        sum_01    = terms[0] + terms[1];
        sum_23    = terms[2] + terms[3];
        sum_0123  = sum_01 + sum_23;
        sum_all   = sum_0123 + terms[4];
        dataout_d = OUT_W'(sum_all >> OUT_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dataout_q <= '0;
        end else begin
            dataout_q <= dataout_d;
        end
    end

    assign dataout = dataout_q;

endmodule

// File: tb/tb_fir_filter.sv
module tb_fir_filter;

    logic       clk;
    logic       rst;
    logic [7:0] x;
    logic [9:0] dataout;

    int n_cmp;
    int n_bad;
    int exp_q[$];

    // Independent window model for the random section.
    int m [5];

    typedef struct {
        logic       r;
        logic [7:0] v;
        int         e;
    } vec_t;

    vec_t vecs[$];

    fir_filter dut (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .dataout (dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag);
        int e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, got %0d", tag, dataout);
        end else begin
            e = exp_q.pop_front();
            if (dataout !== 10'(e)) begin
                n_bad++;
                $display("FAIL %s: got %0d expected %0d at %0t", tag, dataout, e, $time);
            end
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] v, input int e, input string tag);
        @(negedge clk);
        rst = r;
        x   = v;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    function automatic int model_step(input logic r, input int v);
        int e;
        e = r ? ((m[0] + 2 * m[1] + 2 * m[2] + 2 * m[3] + m[4]) >> 1) : 0;
        for (int i = 4; i > 0; i--) m[i] = r ? m[i-1] : 0;
        m[0] = r ? v : 0;
        return e;
    endfunction

    initial begin
        int ramp_head [5];
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        x     = 8'd0;

        // reset with x=255 ignored, then idle zeros
        vecs.push_back('{1'b0, 8'd255, 0});
        vecs.push_back('{1'b0, 8'd255, 0});
        vecs.push_back('{1'b1, 8'd0, 0});
        vecs.push_back('{1'b1, 8'd0, 0});
        vecs.push_back('{1'b1, 8'd0, 0});
        // impulse of 200
        vecs.push_back('{1'b1, 8'd200, 0});
        vecs.push_back('{1'b1, 8'd0, 100});
        vecs.push_back('{1'b1, 8'd0, 200});
        vecs.push_back('{1'b1, 8'd0, 200});
        vecs.push_back('{1'b1, 8'd0, 200});
        vecs.push_back('{1'b1, 8'd0, 100});
        vecs.push_back('{1'b1, 8'd0, 0});
        // unit impulse: odd sums floored
        vecs.push_back('{1'b1, 8'd1, 0});
        vecs.push_back('{1'b1, 8'd0, 0});
        vecs.push_back('{1'b1, 8'd0, 1});
        vecs.push_back('{1'b1, 8'd0, 1});
        vecs.push_back('{1'b1, 8'd0, 1});
        vecs.push_back('{1'b1, 8'd0, 0});
        vecs.push_back('{1'b1, 8'd0, 0});
        // full-scale step from release
        vecs.push_back('{1'b0, 8'd0, 0});
        vecs.push_back('{1'b1, 8'd255, 0});
        vecs.push_back('{1'b1, 8'd255, 127});
        vecs.push_back('{1'b1, 8'd255, 382});
        vecs.push_back('{1'b1, 8'd255, 637});
        vecs.push_back('{1'b1, 8'd255, 892});
        vecs.push_back('{1'b1, 8'd255, 1020});
        vecs.push_back('{1'b1, 8'd255, 1020});
        vecs.push_back('{1'b1, 8'd255, 1020});

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].v, vecs[i].e, $sformatf("vec%0d", i));
        end

        // mid-stream reset: history of 255s must not leak past the clear
        drive(1'b1, 8'd100, 1020, "mid_pre0");
        drive(1'b1, 8'd100, 942, "mid_pre1");
        drive(1'b1, 8'd100, 787, "mid_pre2");
        drive(1'b0, 8'd100, 0, "mid_rst");
        drive(1'b1, 8'd100, 0, "mid_r0");
        drive(1'b1, 8'd100, 50, "mid_r1");
        drive(1'b1, 8'd100, 150, "mid_r2");
        drive(1'b1, 8'd100, 250, "mid_r3");
        drive(1'b1, 8'd100, 350, "mid_r4");
        drive(1'b1, 8'd100, 400, "mid_r5");
        drive(1'b1, 8'd100, 400, "mid_r6");

        // ramp 1,2,3,...; steady state is 4x the middle tap
        drive(1'b0, 8'd0, 0, "ramp_rst");
        ramp_head = '{0, 0, 2, 4, 8};
        for (int k = 1; k <= 14; k++) begin
            if (k < 6) drive(1'b1, 8'(k), ramp_head[k-1], $sformatf("ramp%0d", k));
            else       drive(1'b1, 8'(k), 4 * (k - 3), $sformatf("ramp%0d", k));
        end

        // random stream with occasional resets against the window model
        drive(1'b0, 8'd0, 0, "rand_rst");
        for (int i = 0; i < 5; i++) m[i] = 0;
        for (int i = 0; i < 60; i++) begin
            logic       r;
            logic [7:0] v;
            int         e;
            r = ($urandom_range(0, 15) != 0);
            v = 8'($urandom_range(0, 255));
            e = model_step(r, int'(v));
            drive(r, v, e, $sformatf("rand%0d", i));
        end

        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
